// File: rtl/dmem_mmio_pkg.sv
// Shared constants and address decode for the dmem_mmio data-side memory system.
// The optional cycle counter is selected with the DMEM_MMIO_CYCLES_EN macro in dmem_mmio.sv.
package dmem_mmio_pkg;

  localparam logic [15:0] MMIO_HI = 16'hFFFF;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h0C;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LED,
    SEL_TX,
    SEL_STATUS,
    SEL_CYCLES,
    SEL_NONE
  } sel_e;

  // Accesses are word-wide, so the byte-lane bits never take part in the decode.
  function automatic sel_e decode(input logic [31:0] addr);
    if (addr[31:16] != MMIO_HI) return SEL_RAM;
    case ({addr[7:2], 2'b00})
      OFF_LED:    return SEL_LED;
      OFF_TXDATA: return SEL_TX;
      OFF_STATUS: return SEL_STATUS;
      OFF_CYCLES: return SEL_CYCLES;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Transmit FIFO: push/pop with valid/ready on the read side. A push onto a full FIFO
// that is not popped in the same cycle is dropped and reported on overflow.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;
  logic             accept;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign valid    = !empty;
  assign pop      = valid && ready;
  // A pop frees the slot this cycle's push needs, so push-while-full is legal when popping.
  assign accept   = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign rdata    = empty ? '0 : mem[rd_ptr];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  // NOTE: storage arrays are not reset; resetting the pointers discards the contents.
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (LED, TX FIFO, STATUS, CYCLES) for the single-cycle core.
// Define DMEM_MMIO_CYCLES_EN to build the free-running CYCLES counter at offset 0x0C.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int TX_DEPTH    = 8,
  parameter int LED_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [31:0]      addr_i32,
  input  logic [31:0]      write_data_i32,
  input  logic             enable_wmem_i,
  output logic [31:0]      read_data_o32,
  output logic [LED_W-1:0] led_o,
  output logic [7:0]       tx_data_o8,
  output logic             tx_valid_o,
  input  logic             tx_ready_i
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram [DEPTH_WORDS];
  logic          wr_active;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic          ovf_q;
  logic [31:0]   status;
  logic [31:0]   cycles_rd;

  assign sel       = decode(addr_i32);
  assign ram_idx   = addr_i32[AW+1:2];
  // Stores arriving on a reset edge are dropped.
  assign wr_active = enable_wmem_i && !reset_i;

  always_ff @(posedge clk_i) begin
    if (wr_active && sel == SEL_RAM) ram[ram_idx] <= write_data_i32;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      led_o <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (enable_wmem_i && sel == SEL_LED) led_o <= write_data_i32[LED_W-1:0];
      // Set has priority over a same-cycle software clear.
      if (fifo_ovf)
        ovf_q <= 1'b1;
      else if (enable_wmem_i && sel == SEL_STATUS && write_data_i32[ST_OVF])
        ovf_q <= 1'b0;
    end
  end

  tx_fifo #(
    .WIDTH(8),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (enable_wmem_i && sel == SEL_TX),
    .wdata   (write_data_i32[7:0]),
    .ready   (tx_ready_i),
    .rdata   (tx_data_o8),
    .valid   (tx_valid_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .overflow(fifo_ovf)
  );

`ifdef DMEM_MMIO_CYCLES_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      cycles_q <= '0;
    else if (enable_wmem_i && sel == SEL_CYCLES)
      cycles_q <= write_data_i32;
    else
      cycles_q <= cycles_q + 32'd1;
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_OVF]              = ovf_q;
    status[ST_CNT_LSB +: CW]    = fifo_count;
  end

  // RAM read is asynchronous, so a same-cycle store is only visible after the edge.
  always_comb begin
    read_data_o32 = '0;
    case (sel)
      SEL_RAM:    read_data_o32 = ram[ram_idx];
      SEL_LED:    read_data_o32[LED_W-1:0] = led_o;
      SEL_STATUS: read_data_o32 = status;
      SEL_CYCLES: read_data_o32 = cycles_rd;
      default:    read_data_o32 = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized traffic against
// a queue/array reference model. Honours DMEM_MMIO_CYCLES_EN like the design.
module tb_dmem_mmio;

  localparam int DEPTH_WORDS = 64;
  localparam int TX_DEPTH    = 8;
  localparam int LED_W       = 16;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [31:0]      addr_i32;
  logic [31:0]      write_data_i32;
  logic             enable_wmem_i;
  logic [31:0]      read_data_o32;
  logic [LED_W-1:0] led_o;
  logic [7:0]       tx_data_o8;
  logic             tx_valid_o;
  logic             tx_ready_i;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_ram   [DEPTH_WORDS];
  bit          m_known [DEPTH_WORDS];
  logic [15:0] m_led;
  byte         m_q[$];
  bit          m_ovf;
  logic [31:0] m_cyc;

  always #5 clk = ~clk;

  dmem_mmio #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .TX_DEPTH   (TX_DEPTH),
    .LED_W      (LED_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .addr_i32      (addr_i32),
    .write_data_i32(write_data_i32),
    .enable_wmem_i (enable_wmem_i),
    .read_data_o32 (read_data_o32),
    .led_o         (led_o),
    .tx_data_o8    (tx_data_o8),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i)
  );

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_q.size()) << 8;
    if (m_ovf) s = s | 32'h4;
    if (m_q.size() == 0) s = s | 32'h2;
    if (m_q.size() == TX_DEPTH) s = s | 32'h1;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!is_mmio(a)) return m_ram[word_idx(a)];
    case (a[7:0] & 8'hFC)
      8'h00: return {16'h0, m_led};
      8'h08: return m_status();
`ifdef DMEM_MMIO_CYCLES_EN
      8'h0C: return m_cyc;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_read_known(input logic [31:0] a);
    return is_mmio(a) || m_known[word_idx(a)];
  endfunction

  // Apply one clock edge to the model using the inputs the DUT samples on that edge.
  task automatic model_edge();
    bit mm;
    bit pop;
    bit push;
    logic [7:0] off;
    mm  = is_mmio(addr_i32);
    off = addr_i32[7:0] & 8'hFC;
    if (reset_i) begin
      m_led = '0;
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = '0;
    end else begin
      pop  = (m_q.size() > 0) && tx_ready_i;
      push = enable_wmem_i && mm && off == 8'h04;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < TX_DEPTH) m_q.push_back(byte'(write_data_i32[7:0]));
        else m_ovf = 1'b1;
      end else if (enable_wmem_i && mm && off == 8'h08 && write_data_i32[2]) begin
        m_ovf = 1'b0;
      end
      if (enable_wmem_i && mm && off == 8'h00) m_led = write_data_i32[15:0];
      if (enable_wmem_i && !mm) begin
        m_ram[word_idx(addr_i32)]   = write_data_i32;
        m_known[word_idx(addr_i32)] = 1'b1;
      end
      if (enable_wmem_i && mm && off == 8'h0C) m_cyc = write_data_i32;
      else m_cyc = m_cyc + 32'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic rdy);
    addr_i32       = a;
    write_data_i32 = d;
    enable_wmem_i  = we;
    tx_ready_i     = rdy;
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    reset_i = 1'b0;
    drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
    checks++;
    if (led_o !== '0) begin
      failures++; $display("FAIL reset_led: got %h want 0", led_o);
    end
    checks++;
    if (tx_valid_o !== 1'b0 || tx_data_o8 !== 8'h00) begin
      failures++; $display("FAIL reset_tx: got valid=%b data=%h want 0/00", tx_valid_o, tx_data_o8);
    end
    checks++;
    if (read_data_o32 !== 32'h2) begin
      failures++; $display("FAIL reset_status: got %h want 00000002", read_data_o32);
    end
  endtask

  task automatic test_ram();
    logic [31:0] reads [3];
    reads = '{32'h0000_0010, 32'h0000_0110, 32'h0000_0013};
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step();
    foreach (reads[i]) begin
      drive(reads[i], 32'h0, 1'b0, 1'b0);
      checks++;
      if (read_data_o32 !== 32'hDEAD_BEEF) begin
        failures++; $display("FAIL ram_read[%0d]: got %h want deadbeef", i, read_data_o32);
      end
    end
    // Same-cycle write and read returns the old word; new word visible after the edge.
    drive(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0);
    checks++;
    if (read_data_o32 !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ram_rw_old: got %h want deadbeef", read_data_o32);
    end
    step();
    drive(32'h0000_0010, 32'h0, 1'b0, 1'b0);
    checks++;
    if (read_data_o32 !== 32'h1234_5678) begin
      failures++; $display("FAIL ram_rw_new: got %h want 12345678", read_data_o32);
    end
  endtask

  task automatic test_led();
    drive(32'hFFFF_0000, 32'h0001_A5A5, 1'b1, 1'b0);
    step();
    drive(32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
    checks++;
    if (led_o !== 16'hA5A5) begin
      failures++; $display("FAIL led_out: got %h want a5a5", led_o);
    end
    checks++;
    if (read_data_o32 !== 32'h0000_A5A5) begin
      failures++; $display("FAIL led_read: got %h want 0000a5a5", read_data_o32);
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    checks++;
    if (led_o !== '0) begin
      failures++; $display("FAIL led_reset: got %h want 0", led_o);
    end
  endtask

  task automatic fill_fifo();
    for (int i = 0; i < TX_DEPTH; i++) begin
      drive(32'hFFFF_0004, 32'(8'h41 + i), 1'b1, 1'b0);
      step();
    end
  endtask

  task automatic test_fifo_overflow();
    fill_fifo();
    drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
    checks++;
    if (read_data_o32 !== 32'h0000_0801) begin
      failures++; $display("FAIL fifo_full_status: got %h want 00000801", read_data_o32);
    end
    drive(32'hFFFF_0004, 32'h49, 1'b1, 1'b0);
    step();
    drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
    checks++;
    if (read_data_o32 !== 32'h0000_0805) begin
      failures++; $display("FAIL fifo_ovf_status: got %h want 00000805", read_data_o32);
    end
    drive(32'hFFFF_0008, 32'h4, 1'b1, 1'b0);
    step();
    drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
    checks++;
    if (read_data_o32 !== 32'h0000_0801) begin
      failures++; $display("FAIL fifo_ovf_clear: got %h want 00000801", read_data_o32);
    end
  endtask

  task automatic test_fifo_drain();
    for (int i = 0; i < TX_DEPTH; i++) begin
      drive(32'h0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o8 !== 8'(8'h41 + i)) begin
        failures++;
        $display("FAIL drain[%0d]: got valid=%b data=%h want 1/%h", i, tx_valid_o, tx_data_o8,
                 8'(8'h41 + i));
      end
      step();
    end
    drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b1);
    checks++;
    if (tx_valid_o !== 1'b0 || read_data_o32 !== 32'h2) begin
      failures++; $display("FAIL drain_empty: got valid=%b status=%h want 0/00000002",
                           tx_valid_o, read_data_o32);
    end
  endtask

  task automatic test_back_to_back();
    byte exp_bytes [TX_DEPTH];
    fill_fifo();
    drive(32'hFFFF_0004, 32'h50, 1'b1, 1'b1);
    step();
    drive(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
    checks++;
    if (read_data_o32 !== 32'h0000_0801) begin
      failures++; $display("FAIL b2b_status: got %h want 00000801", read_data_o32);
    end
    for (int i = 0; i < TX_DEPTH - 1; i++) exp_bytes[i] = byte'(8'h42 + i);
    exp_bytes[TX_DEPTH-1] = 8'h50;
    for (int i = 0; i < TX_DEPTH; i++) begin
      drive(32'h0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o8 !== exp_bytes[i]) begin
        failures++;
        $display("FAIL b2b_drain[%0d]: got valid=%b data=%h want 1/%h", i, tx_valid_o,
                 tx_data_o8, exp_bytes[i]);
      end
      step();
    end
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (tx_valid_o !== 1'b0) begin
      failures++; $display("FAIL b2b_empty: got valid=%b want 0", tx_valid_o);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] exp [3];
`ifdef DMEM_MMIO_CYCLES_EN
    exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
`else
    exp = '{32'h0, 32'h0, 32'h0};
`endif
    drive(32'hFFFF_000C, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
      checks++;
      if (read_data_o32 !== exp[i]) begin
        failures++; $display("FAIL cycles[%0d]: got %h want %h", i, read_data_o32, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [7:0]  offs [6];
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  exp_tx;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40};
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 55) a = {1'b0, 31'($urandom)};
      else a = {16'hFFFF, 8'($urandom), offs[$urandom_range(5)]};
      d = $urandom;
      if ($urandom_range(3) == 0) d[2] = 1'b1;
      reset_i = ($urandom_range(99) < 2);
      drive(a, d, 1'($urandom_range(1)), 1'($urandom_range(1)));
      if (m_read_known(a)) begin
        checks++;
        if (read_data_o32 !== m_read(a)) begin
          failures++; $display("FAIL rnd_read[%0d] @%h: got %h want %h", n, a, read_data_o32,
                               m_read(a));
        end
      end
      exp_tx = (m_q.size() > 0) ? m_q[0] : 8'h00;
      checks++;
      if (tx_valid_o !== (m_q.size() > 0) || tx_data_o8 !== exp_tx || led_o !== m_led) begin
        failures++;
        $display("FAIL rnd_out[%0d]: got valid=%b data=%h led=%h want %b/%h/%h", n, tx_valid_o,
                 tx_data_o8, led_o, m_q.size() > 0, exp_tx, m_led);
      end
      step();
    end
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i        = 1'b1;
    addr_i32       = '0;
    write_data_i32 = '0;
    enable_wmem_i  = 1'b0;
    tx_ready_i     = 1'b0;
    m_led          = '0;
    m_ovf          = 1'b0;
    m_cyc          = '0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    test_reset();
    test_ram();
    test_led();
    test_fifo_overflow();
    test_fifo_drain();
    test_back_to_back();
    test_cycles();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
